// File: rtl/tlb_cmd_ctrl.sv
// CP0-side TLB command initiator: holds the TLB-management CP0 registers, drives them to the MMU,
// and sequences TLBP/TLBR/TLBWI/TLBWR into single-cycle command strobes with result write-back.
module tlb_cmd_ctrl #(
  parameter int unsigned ENTRY_ADDR_WIDTH = 3
) (
  input  logic        clk,
  input  logic        res,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic        op_valid,
  input  logic [1:0]  op,
  output logic        op_ready,
  output logic        op_done,
  input  logic        exc_tlb,
  input  logic [31:0] exc_badVAddr,
  output logic [31:0] mmu_index,
  output logic [31:0] mmu_random,
  output logic [31:0] mmu_entryLo0,
  output logic [31:0] mmu_entryLo1,
  output logic [31:0] mmu_ctx,
  output logic [31:0] mmu_pageMask,
  output logic [31:0] mmu_wired,
  output logic [31:0] mmu_entryHi,
  output logic [1:0]  mmu_cmd,
  output logic        mmu_cmdValid,
  input  logic [31:0] matchedIndex,
  input  logic        mmu_tlbMiss,
  input  logic [31:0] tlb_rdEntryHi,
  input  logic [31:0] tlb_rdEntryLo0,
  input  logic [31:0] tlb_rdEntryLo1,
  input  logic [31:0] tlb_rdPageMask
);
  localparam int unsigned AW = ENTRY_ADDR_WIDTH;
  localparam logic [1:0]  OP_TLBP = 2'd0;
  localparam logic [1:0]  OP_TLBR = 2'd1;

  localparam logic [31:0] IDX_M  = {{(32-AW){1'b0}}, {AW{1'b1}}};
  localparam logic [31:0] ELO_M  = 32'h3fff_ffff;
  localparam logic [31:0] CTX_M  = 32'hff80_0000;
  localparam logic [31:0] PM_M   = 32'h1fff_e000;
  localparam logic [31:0] EH_M   = 32'hffff_e0ff;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DONE} state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [31:0]     index_q, index_d;
  logic [AW-1:0]   random_q, random_d;
  logic [AW-1:0]   wired_q, wired_d;
  logic [31:0]     elo0_q, elo0_d;
  logic [31:0]     elo1_q, elo1_d;
  logic [31:0]     ctx_q, ctx_d;
  logic [31:0]     pm_q, pm_d;
  logic [31:0]     eh_q, eh_d;
  logic            capture;
  logic            unused_badvaddr_low;

  assign unused_badvaddr_low = ^exc_badVAddr[12:0];

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    op_ready     = 1'b0;
    op_done      = 1'b0;
    mmu_cmdValid = 1'b0;
    capture      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          state_d = ST_ISSUE;
          op_d    = op;
        end
      end
      ST_ISSUE: begin
        mmu_cmdValid = 1'b1;
        capture      = 1'b1;
        state_d      = ST_DONE;
      end
      ST_DONE: begin
        op_done = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Later assignments override earlier ones: capture beats exc_tlb beats MTC0 per register.
  always_comb begin
    index_d = index_q;
    if (cp0_we && cp0_addr == 5'd0) index_d = (index_q & ~IDX_M) | (cp0_wdata & IDX_M);
    if (capture && op_q == OP_TLBP)
      index_d = mmu_tlbMiss ? 32'h8000_0000 : (matchedIndex & IDX_M);

    wired_d = wired_q;
    if (cp0_we && cp0_addr == 5'd6) wired_d = cp0_wdata[AW-1:0];

    // Random is held during ISSUE so a TLBWR sees a stable index on its strobe.
    if (cp0_we && cp0_addr == 5'd6)  random_d = '1;
    else if (state_q == ST_ISSUE)    random_d = random_q;
    else if (random_q <= wired_q)    random_d = '1;
    else                             random_d = random_q - AW'(1);

    elo0_d = elo0_q;
    if (cp0_we && cp0_addr == 5'd2) elo0_d = cp0_wdata & ELO_M;
    if (capture && op_q == OP_TLBR) elo0_d = tlb_rdEntryLo0 & ELO_M;

    elo1_d = elo1_q;
    if (cp0_we && cp0_addr == 5'd3) elo1_d = cp0_wdata & ELO_M;
    if (capture && op_q == OP_TLBR) elo1_d = tlb_rdEntryLo1 & ELO_M;

    pm_d = pm_q;
    if (cp0_we && cp0_addr == 5'd5) pm_d = cp0_wdata & PM_M;
    if (capture && op_q == OP_TLBR) pm_d = tlb_rdPageMask & PM_M;

    ctx_d = ctx_q;
    if (cp0_we && cp0_addr == 5'd4) ctx_d = (ctx_q & ~CTX_M) | (cp0_wdata & CTX_M);
    if (exc_tlb) ctx_d = {ctx_q[31:23], exc_badVAddr[31:13], ctx_q[3:0]};

    eh_d = eh_q;
    if (cp0_we && cp0_addr == 5'd10) eh_d = cp0_wdata & EH_M;
    if (exc_tlb) eh_d = {exc_badVAddr[31:13], eh_q[12:0]};
    if (capture && op_q == OP_TLBR) eh_d = tlb_rdEntryHi & EH_M;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_TLBP;
      index_q  <= '0;
      random_q <= '1;
      wired_q  <= '0;
      elo0_q   <= '0;
      elo1_q   <= '0;
      ctx_q    <= '0;
      pm_q     <= '0;
      eh_q     <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      index_q  <= index_d;
      random_q <= random_d;
      wired_q  <= wired_d;
      elo0_q   <= elo0_d;
      elo1_q   <= elo1_d;
      ctx_q    <= ctx_d;
      pm_q     <= pm_d;
      eh_q     <= eh_d;
    end
  end

  assign mmu_index    = index_q;
  assign mmu_random   = {{(32-AW){1'b0}}, random_q};
  assign mmu_entryLo0 = elo0_q;
  assign mmu_entryLo1 = elo1_q;
  assign mmu_ctx      = ctx_q;
  assign mmu_pageMask = pm_q;
  assign mmu_wired    = {{(32-AW){1'b0}}, wired_q};
  assign mmu_entryHi  = eh_q;
  assign mmu_cmd      = op_q;

  always_comb begin
    cp0_rdata = '0;
    unique case (cp0_addr)
      5'd0:    cp0_rdata = mmu_index;
      5'd1:    cp0_rdata = mmu_random;
      5'd2:    cp0_rdata = mmu_entryLo0;
      5'd3:    cp0_rdata = mmu_entryLo1;
      5'd4:    cp0_rdata = mmu_ctx;
      5'd5:    cp0_rdata = mmu_pageMask;
      5'd6:    cp0_rdata = mmu_wired;
      5'd10:   cp0_rdata = mmu_entryHi;
      default: cp0_rdata = '0;
    endcase
  end
endmodule
